input_vc_unit: RTL
==================

INPUT_VC_UNIT -- requirements
Module: input_vc_unit

Interface
REQ-001 Parameter VC_NUM, default 2, number of virtual channels on this input port.
REQ-002 Parameter BUFFER_SIZE, default 8, flit depth per VC, power of two.
REQ-003 Parameter ON_OFF_RTT, default 3, free-slot margin reserved for in-flight flits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 data_i  in  flit_t  incoming flit: label, vc_id, next_hop_port (lookahead route), payload.
REQ-007 valid_flit_i  in  1  data_i valid this cycle.
REQ-008 vc_request_o  out  VC_NUM  VC requests a downstream VC from the VC allocator.
REQ-009 vc_valid_i  in  VC_NUM  VC allocation granted this cycle.
REQ-010 vc_new_i  in  VC_NUM x VC_SIZE  granted downstream VC id.
REQ-011 switch_request_o  out  VC_NUM  VC requests the crossbar from the switch allocator.
REQ-012 out_port_o  out  VC_NUM x PORT_SIZE  output port of the packet held by each VC.
REQ-013 downstream_vc_o  out  VC_NUM x VC_SIZE  downstream VC bound to each VC.
REQ-014 vc_sel_i  in  VC_SIZE  VC chosen by the switch allocator.
REQ-015 valid_sel_i  in  1  vc_sel_i valid; pop that VC this cycle.
REQ-016 flit_o  out  flit_t  head flit of VC vc_sel_i, with vc_id replaced by downstream_vc_o[vc_sel_i].
REQ-017 on_off_o  out  VC_NUM  per-VC upstream flow control; 1 = upstream may send.
REQ-018 error_o  out  1  sticky error flag.

Function
REQ-019 A valid flit is written into the FIFO of VC data_i.vc_id and appears at that FIFO head no earlier than the next cycle.
REQ-020 Each VC runs an FSM with states IDLE, VA and ACTIVE.
REQ-021 IDLE -> VA: the FIFO head is a HEAD or HEADTAIL flit; latch out_port_o from next_hop_port.
REQ-022 VA: assert vc_request_o; on vc_valid_i, latch vc_new_i into downstream_vc_o and go to ACTIVE.
REQ-023 ACTIVE: assert switch_request_o whenever the FIFO is non-empty.
REQ-024 A pop with valid_sel_i occurs combinationally on flit_o and takes effect at the clock edge.
REQ-025 Popping a TAIL or HEADTAIL flit returns the VC to IDLE; a following HEAD re-enters VA on the next cycle at the earliest.
REQ-026 Simultaneous push and pop on the same VC is legal; occupancy is unchanged.
REQ-027 Push to a full VC drops the flit and sets error_o.
REQ-028 valid_sel_i for a VC not in ACTIVE, or with an empty FIFO, causes no pop and sets error_o.
REQ-029 A non-HEAD flit at the head of an IDLE VC sets error_o and is not consumed.
REQ-030 on_off_o[v] is a registered value equal to 1 iff free slots of v at the previous edge > ON_OFF_RTT.
REQ-031 Read and write pointers are log2(BUFFER_SIZE) bits and wrap modulo BUFFER_SIZE; the occupancy counter is log2(BUFFER_SIZE)+1 bits.

Reset
REQ-032 While rst is asserted:
- all VCs are IDLE and FIFOs are empty;
- vc_request_o, switch_request_o, out_port_o, downstream_vc_o and error_o are 0;
- on_off_o is all 1.
REQ-033 rst asserted mid-packet discards all buffered flits; no partial state survives.

Structure
REQ-034 flit_t, flit_label_t (HEAD, BODY, TAIL, HEADTAIL), vc_state_t, VC_NUM, VC_SIZE, PORT_NUM, PORT_SIZE and BUFFER_SIZE live in noc_params.
REQ-035 Each VC FIFO is one instance of sub-module circular_buffer (push, pop, data, empty, full, free-count).

Verification
REQ-036 HEADTAIL on VC0 with next_hop_port=2 -> VA next cycle; after vc_valid_i[0], vc_new_i=1 -> ACTIVE with out_port_o[0]=2 and switch_request_o[0]=1; on pop, flit_o.vc_id=1 and VC0 returns to IDLE.
REQ-037 Five-flit packet HEAD, BODY x3, TAIL with one pop per cycle -> five flits out in order; IDLE after the TAIL.
REQ-038 BUFFER_SIZE=8, ON_OFF_RTT=3, fill VC1 to 5 flits -> on_off_o[1]=0 one cycle later; pop one flit -> on_off_o[1]=1.
REQ-039 Push and pop on VC0 in the same cycle at occupancy 8 -> no error, occupancy stays 8; a ninth push with no pop -> error_o=1.
REQ-040 Assert rst mid-packet on both VCs -> all outputs at reset values immediately; a new HEAD after release is accepted.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC parameters and flit/VC types used by the router input stage.
package noc_params;

    localparam int VC_NUM       = 2;
    localparam int VC_SIZE      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_NUM     = 5;
    localparam int PORT_SIZE    = $clog2(PORT_NUM);
    localparam int BUFFER_SIZE  = 8;
    localparam int PAYLOAD_SIZE = 16;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
    typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

    typedef struct packed {
        flit_label_t             label;
        logic [VC_SIZE-1:0]      vc_id;
        logic [PORT_SIZE-1:0]    next_hop_port;
        logic [PAYLOAD_SIZE-1:0] payload;
    } flit_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/circular_buffer.sv
// Single-clock flit FIFO for one virtual channel; head flit is readable combinationally.
module circular_buffer
    import noc_params::*;
#(
    parameter int DEPTH = BUFFER_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  flit_t                    data_i,
    output flit_t                    data_o,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int PTR_W = $clog2(DEPTH);

    flit_t              mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               do_pop;
    logic               do_push;

    // A full buffer still accepts a write when the same edge frees a slot.
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign empty      = (count == '0);
    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign free_count = (PTR_W+1)'(DEPTH) - count;
    assign data_o     = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count define validity, and a reset would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_unit.sv
// Router input port: per-VC flit buffering, IDLE/VA/ACTIVE control and on/off flow control.
module input_vc_unit
    import noc_params::*;
#(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE,
    parameter int ON_OFF_RTT  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  flit_t                             data_i,
    input  logic                              valid_flit_i,
    output logic [VC_NUM-1:0]                 vc_request_o,
    input  logic [VC_NUM-1:0]                 vc_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]    vc_new_i,
    output logic [VC_NUM-1:0]                 switch_request_o,
    output logic [VC_NUM-1:0][PORT_SIZE-1:0]  out_port_o,
    output logic [VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_o,
    input  logic [VC_SIZE-1:0]                vc_sel_i,
    input  logic                              valid_sel_i,
    output flit_t                             flit_o,
    output logic [VC_NUM-1:0]                 on_off_o,
    output logic                              error_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    vc_state_t                          state      [VC_NUM];
    vc_state_t                          state_next [VC_NUM];
    flit_t                              head       [VC_NUM];
    logic [CNT_W-1:0]                   free_count [VC_NUM];
    logic [VC_NUM-1:0]                  empty;
    logic [VC_NUM-1:0]                  full;
    logic [VC_NUM-1:0]                  push;
    logic [VC_NUM-1:0]                  pop;
    logic [VC_NUM-1:0][PORT_SIZE-1:0]   out_port_next;
    logic [VC_NUM-1:0][VC_SIZE-1:0]     downstream_next;
    logic                               error_next;
    logic                               sel_ok;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        circular_buffer #(.DEPTH(BUFFER_SIZE)) u_buf (
            .clk        (clk),
            .rst        (rst),
            .push       (push[v]),
            .pop        (pop[v]),
            .data_i     (data_i),
            .data_o     (head[v]),
            .empty      (empty[v]),
            .full       (full[v]),
            .free_count (free_count[v])
        );
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next       = state;
        out_port_next    = out_port_o;
        downstream_next  = downstream_vc_o;
        error_next       = error_o;
        vc_request_o     = '0;
        switch_request_o = '0;
        push             = '0;
        pop              = '0;

        sel_ok = valid_sel_i && (state[vc_sel_i] == ACTIVE) && !empty[vc_sel_i];
        if (valid_sel_i && !sel_ok) error_next = 1'b1;

        if (valid_flit_i) begin
            push[data_i.vc_id] = 1'b1;
            if (full[data_i.vc_id] && !(sel_ok && (vc_sel_i == data_i.vc_id)))
                error_next = 1'b1;
        end

        for (int v = 0; v < VC_NUM; v++) begin
            pop[v] = sel_ok && (vc_sel_i == VC_SIZE'(v));
            case (state[v])
                IDLE: begin
                    // A stray non-head flit is left in place so the fault stays visible.
                    if (!empty[v]) begin
                        if (is_head(head[v].label)) begin
                            state_next[v]    = VA;
                            out_port_next[v] = head[v].next_hop_port;
                        end else begin
                            error_next = 1'b1;
                        end
                    end
                end
                VA: begin
                    vc_request_o[v] = 1'b1;
                    if (vc_valid_i[v]) begin
                        state_next[v]      = ACTIVE;
                        downstream_next[v] = vc_new_i[v];
                    end
                end
                ACTIVE: begin
                    switch_request_o[v] = !empty[v];
                    if (pop[v] && is_tail(head[v].label)) state_next[v] = IDLE;
                end
                default: state_next[v] = IDLE;
            endcase
        end
    end

    always_comb begin
        flit_o       = head[vc_sel_i];
        flit_o.vc_id = downstream_vc_o[vc_sel_i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) state[v] <= IDLE;
            out_port_o      <= '0;
            downstream_vc_o <= '0;
            error_o         <= 1'b0;
            on_off_o        <= '1;
        end else begin
            state           <= state_next;
            out_port_o      <= out_port_next;
            downstream_vc_o <= downstream_next;
            error_o         <= error_next;
            for (int v = 0; v < VC_NUM; v++)
                on_off_o[v] <= (free_count[v] > CNT_W'(ON_OFF_RTT));
        end
    end

endmodule
